// File: rtl/shrv32_pkg.sv
// shrv32_pkg: constants and types shared by the shrv32 fetch and decode stages
package shrv32_pkg;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam logic [4:0]  OPC_LOAD   = 5'b00000;
  localparam logic [4:0]  OPC_OPIMM  = 5'b00100;
  localparam logic [4:0]  OPC_AUIPC  = 5'b00101;
  localparam logic [4:0]  OPC_STORE  = 5'b01000;
  localparam logic [4:0]  OPC_OP     = 5'b01100;
  localparam logic [4:0]  OPC_LUI    = 5'b01101;
  localparam logic [4:0]  OPC_BRANCH = 5'b11000;
  localparam logic [4:0]  OPC_JALR   = 5'b11001;
  localparam logic [4:0]  OPC_JAL    = 5'b11011;
  localparam logic [4:0]  OPC_SYSTEM = 5'b11100;
  typedef enum logic [1:0] {BOOT, RUN, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with clear; registered storage, no write-to-read bypass
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (clr) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= inc(wp);
      if (pop) rp <= inc(rp);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push && !clr) mem[wp] <= din;
  assign dout = mem[rp];
  assign empty = count == '0;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: shrv32 fetch stage; credit-limited in-order imem reads buffered for decode
module instr_fetch_unit
  import shrv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  output logic [4:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);
  localparam int CW = $clog2(FIFO_DEPTH + 1) + 1;
  fetch_state_t state, state_d;
  logic [31:0] fetch_pc, resp_pc;
  logic [CW-1:0] inflight, inflight_d, drop_cnt, drop_d, count;
  logic [63:0] head;
  logic empty, req_fire, resp_live, push, pop, unused_ok;
  assign unused_ok = &{1'b0, redirect_pc[1:0]};
  assign req_fire = imem_req_valid & imem_req_ready;
  // with no request outstanding (e.g. just after reset) a response is not ours
  assign resp_live = imem_resp_valid & ((drop_cnt != '0) | (inflight != '0));
  assign push = resp_live & (drop_cnt == '0) & !redirect_valid;
  assign pop = dec_valid & dec_ready & !redirect_valid;
  assign imem_req_valid = (state != BOOT) & !redirect_valid &
                          ((inflight + count + drop_cnt) < CW'(FIFO_DEPTH));
  assign imem_req_addr = fetch_pc;
  // live requests are consecutive words ending just below fetch_pc
  assign resp_pc = fetch_pc - {inflight, 2'b00};
  always_comb begin
    inflight_d = redirect_valid ? '0 : inflight + CW'(req_fire) - CW'(push);
    drop_d = redirect_valid ? drop_cnt + inflight - CW'(resp_live)
                            : drop_cnt - CW'(resp_live & (drop_cnt != '0));
    state_d = state == BOOT ? RUN : (drop_d != '0 ? DRAIN : RUN);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= BOOT;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_d;
      inflight <= inflight_d;
      drop_cnt <= drop_d;
      fetch_pc <= redirect_valid ? {redirect_pc[31:2], 2'b00} : req_fire ? fetch_pc + 32'd4 : fetch_pc;
    end
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64), .CW(CW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .clr(redirect_valid),
    .push(push),
    .din({resp_pc, imem_resp_data}),
    .pop(pop),
    .dout(head),
    .count(count),
    .empty(empty)
  );
  assign dec_valid = !empty;
  assign dec_inst = empty ? NOP_INST : head[31:0];
  assign dec_pc = empty ? fetch_pc : head[63:32];
  assign opcode = dec_inst[6:2];
  assign funct3 = dec_inst[14:12];
  assign funct7 = dec_inst[31:25];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random checks of the fetch stage against a queue-based model
module tb_instr_fetch_unit;
  localparam int DEPTH = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;
  logic clk = 0, rst = 1;
  logic imem_req_valid, imem_req_ready = 0, imem_resp_valid = 0, redirect_valid = 0;
  logic dec_valid, dec_ready = 0;
  logic [31:0] imem_req_addr, imem_resp_data = 0, redirect_pc = 0, dec_inst, dec_pc;
  logic [4:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  always #5 clk = ~clk;
  instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_inst(dec_inst), .dec_pc(dec_pc),
    .opcode(opcode), .funct3(funct3), .funct7(funct7)
  );
  typedef struct { logic [31:0] addr; int gen; bit orphan; } req_t;
  req_t memq[$];
  logic [31:0] exp_q[$], req_log[$], pop_log[$];
  logic [31:0] exp_req_addr = RPC, stream_pc = RPC;
  int total = 0, bad = 0, gen = 0, nreq = 0, npop = 0, base;
  bit boot = 1;
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], 16'h5A13};
  endfunction
  function automatic int live();
    int n = 0;
    foreach (memq[i]) if (!memq[i].orphan && memq[i].gen == gen) n++;
    return n;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input bit rdy, input bit rsp, input bit drdy, input bit redir, input logic [31:0] rpc);
    int used;
    bit ev, erv;
    logic [31:0] w;
    req_t m;
    @(negedge clk);
    imem_req_ready = rdy && !(memq.size() > 0 && memq[0].orphan);
    imem_resp_valid = rsp && memq.size() > 0;
    imem_resp_data = memq.size() > 0 ? memfn(memq[0].addr) : 32'h0;
    dec_ready = drdy;
    redirect_valid = redir;
    redirect_pc = rpc;
    #1;
    used = exp_q.size() + 0;
    foreach (memq[i]) if (!memq[i].orphan) used++;
    ev = exp_q.size() > 0;
    erv = !boot && !redir && used < DEPTH;
    chk("req_valid", 32'(imem_req_valid), 32'(erv));
    chk("dec_valid", 32'(dec_valid), 32'(ev));
    if (ev) begin
      w = memfn(exp_q[0]);
      chk("dec_pc", dec_pc, exp_q[0]);
      chk("dec_inst", dec_inst, w);
      chk("opcode", 32'(opcode), 32'(w[6:2]));
      chk("funct3", 32'(funct3), 32'(w[14:12]));
      chk("funct7", 32'(funct7), 32'(w[31:25]));
    end else begin
      chk("nop_inst", dec_inst, 32'h0000_0013);
      chk("nop_opcode", 32'(opcode), 32'h4);
    end
    if (imem_resp_valid) begin
      m = memq.pop_front();
      if (!redir && !m.orphan && m.gen == gen) exp_q.push_back(m.addr);
    end
    if (redir) begin
      exp_q.delete();
      gen++;
      exp_req_addr = {rpc[31:2], 2'b00};
      stream_pc = exp_req_addr;
    end else if (ev && drdy) begin
      chk("stream_pc", dec_pc, stream_pc);
      pop_log.push_back(dec_pc);
      stream_pc += 32'd4;
      npop++;
      void'(exp_q.pop_front());
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_req_addr);
      req_log.push_back(imem_req_addr);
      memq.push_back('{exp_req_addr, gen, 1'b0});
      exp_req_addr += 32'd4;
      nreq++;
    end
    boot = 0;
  endtask
  task automatic do_reset();
    #2 rst = 1;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_dec_valid", 32'(dec_valid), 32'h0);
    chk("rst_dec_inst", dec_inst, 32'h0000_0013);
    chk("rst_dec_pc", dec_pc, RPC);
    foreach (memq[i]) memq[i].orphan = 1;
    exp_q.delete();
    gen++;
    exp_req_addr = RPC;
    stream_pc = RPC;
    @(posedge clk);
    #2 rst = 0;
    boot = 1;
  endtask
  initial begin
    #1;
    chk("init_req_valid", 32'(imem_req_valid), 32'h0);
    chk("init_dec_inst", dec_inst, 32'h0000_0013);
    chk("init_dec_pc", dec_pc, RPC);
    @(posedge clk);
    #2 rst = 0;
    // 1: 1-cycle memory, fetch 0,4,8,... in order
    base = npop;
    req_log.delete();
    repeat (12) cyc(1, 1, 1, 0, 0);
    chk("t1_pops", npop - base, 6);
    chk("t1_addr0", req_log[0], 32'h0);
    chk("t1_addr2", req_log[2], 32'h8);
    // 2: decode stalled: credit allows exactly DEPTH requests
    do_reset();
    base = nreq;
    repeat (10) cyc(1, 1, 0, 0, 0);
    chk("t2_reqs", nreq - base, DEPTH);
    // 3: redirect with two requests in flight
    for (int k = 0; k < 20 && live() < 2; k++) cyc(1, 0, 1, 0, 0);
    chk("t3_inflight", live(), 2);
    pop_log.delete();
    cyc(1, 0, 1, 1, 32'h100);
    repeat (12) cyc(1, 1, 1, 0, 0);
    chk("t3_first_pc", pop_log.size() > 0 ? pop_log[0] : 32'hDEAD_BEEF, 32'h100);
    // 4: unaligned redirect target and PC wrap
    req_log.delete();
    cyc(1, 1, 1, 1, 32'h103);
    repeat (6) cyc(1, 1, 1, 0, 0);
    chk("t4_aligned", req_log.size() > 0 ? req_log[0] : 32'hDEAD_BEEF, 32'h100);
    req_log.delete();
    cyc(1, 1, 1, 1, 32'hFFFF_FFFC);
    repeat (8) cyc(1, 1, 1, 0, 0);
    chk("t4_last", req_log.size() > 1 ? req_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("t4_wrap", req_log.size() > 1 ? req_log[1] : 32'hDEAD_BEEF, 32'h0);
    // 5: redirect coinciding with a response and a pop
    cyc(1, 0, 0, 1, 32'h200);
    for (int k = 0; k < 20 && live() < 2; k++) cyc(1, memq.size() > 0 && memq[0].gen != gen, 0, 0, 0);
    chk("t5_inflight", live(), 2);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 1, 1, 32'h300);
    @(posedge clk);
    #1;
    chk("t5_empty", 32'(dec_valid), 32'h0);
    repeat (8) cyc(1, 1, 1, 0, 0);
    // 6: asynchronous reset with requests in flight
    for (int k = 0; k < 20 && live() < 2; k++) cyc(1, 0, 1, 0, 0);
    chk("t6_inflight", live(), 2);
    do_reset();
    req_log.delete();
    repeat (8) cyc(1, 1, 1, 0, 0);
    chk("t6_first_addr", req_log.size() > 0 ? req_log[0] : 32'hDEAD_BEEF, RPC);
    // random traffic, redirects and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 24) == 0, $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
